// File: rtl/mod3_seq_checker.sv
// Lock-and-check monitor for a 2-bit mod-3 count stream (00 -> 01 -> 10 -> 00).
// It hunts for a run of legal transitions, locks, then flags and counts violations.
module mod3_seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             en,
    input  logic [1:0]       in_count,
    input  logic             clear_err,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       expected
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = LOCK_CNT[3:0];

    state_t           state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic [3:0]       run_q, run_d;
    logic             miss_q, miss_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [1:0]       expected_q, expected_d;
    logic             good;

    // Successor on the legal cycle; 11 has no successor and maps to 00.
    function automatic logic [1:0] nxt(input logic [1:0] v);
        case (v)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd0;
            default: nxt = 2'd0;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        miss_d      = miss_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        good        = (prev_q != 2'd3) && (in_count == nxt(prev_q));

        if (en) begin
            prev_d = in_count;
            case (state_q)
                IDLE: begin
                    run_d   = 4'd0;
                    state_d = HUNT;
                end
                HUNT: begin
                    if (good) begin
                        if (run_q + 4'd1 == LOCK_TGT) begin
                            state_d = LOCKED;
                            run_d   = 4'd0;
                            miss_d  = 1'b0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        // A second consecutive miss means we lost the stream.
                        if (miss_q) begin
                            state_d = HUNT;
                            run_d   = 4'd0;
                            miss_d  = 1'b0;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = 4'd0;
                    miss_d  = 1'b0;
                end
            endcase
        end

        if (clear_err) begin
            err_count_d = '0;
        end

        if (state_d == IDLE || prev_d == 2'd3) begin
            expected_d = 2'd0;
        end else begin
            expected_d = nxt(prev_d);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            prev_q      <= 2'd0;
            run_q       <= 4'd0;
            miss_q      <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            expected_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            expected_q  <= expected_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign err       = err_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;

endmodule

// File: tb/tb_mod3_seq_checker.sv
// Scoreboard bench for mod3_seq_checker: two instances (8-bit and 2-bit error
// counters) share stimulus; a reference model queues expected outputs per edge.
module tb_mod3_seq_checker;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       en;
    logic [1:0] in_count;
    logic       clear_err;

    logic       locked_a, err_a;
    logic [7:0] err_count_a;
    logic [1:0] expected_a;
    logic       locked_b, err_b;
    logic [1:0] err_count_b;
    logic [1:0] expected_b;

    mod3_seq_checker #(.LOCK_CNT(3), .ERR_W(8)) dut_a (
        .Clk(Clk), .Rst(Rst), .en(en), .in_count(in_count), .clear_err(clear_err),
        .locked(locked_a), .err(err_a), .err_count(err_count_a), .expected(expected_a)
    );

    mod3_seq_checker #(.LOCK_CNT(3), .ERR_W(2)) dut_b (
        .Clk(Clk), .Rst(Rst), .en(en), .in_count(in_count), .clear_err(clear_err),
        .locked(locked_b), .err(err_b), .err_count(err_count_b), .expected(expected_b)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       locked;
        logic       err;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
        logic [1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: 0 idle, 1 hunt, 2 locked
    int         m_state;
    logic [1:0] m_prev;
    int         m_run;
    logic       m_miss;
    logic       m_err;
    int         m_cnt8;
    int         m_cnt2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    endtask

    function automatic logic [1:0] ref_succ(input logic [1:0] v);
        logic [1:0] tbl [4];
        tbl[0] = 2'b01; tbl[1] = 2'b10; tbl[2] = 2'b00; tbl[3] = 2'b00;
        return tbl[v];
    endfunction

    task automatic model_reset();
        m_state = 0; m_prev = 2'd0; m_run = 0; m_miss = 1'b0;
        m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(input logic e, input logic [1:0] d, input logic c);
        bit ok;
        m_err = 1'b0;
        if (e) begin
            ok = (m_prev != 2'b11) && (d == ref_succ(m_prev));
            if (m_state == 0) begin
                m_state = 1; m_run = 0;
            end else if (m_state == 1) begin
                if (!ok) m_run = 0;
                else if (m_run + 1 >= 3) begin m_state = 2; m_run = 0; m_miss = 0; end
                else m_run = m_run + 1;
            end else begin
                if (ok) m_miss = 0;
                else begin
                    m_err = 1'b1;
                    m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                    m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                    if (m_miss) begin m_state = 1; m_run = 0; m_miss = 0; end
                    else m_miss = 1;
                end
            end
            m_prev = d;
        end
        if (c) begin m_cnt8 = 0; m_cnt2 = 0; end
    endtask

    task automatic step(input logic e, input logic [1:0] d, input logic c);
        exp_t x;
        exp_t y;
        en = e; in_count = d; clear_err = c;
        model_step(e, d, c);
        x.locked = (m_state == 2);
        x.err    = m_err;
        x.cnt8   = 8'(m_cnt8);
        x.cnt2   = 2'(m_cnt2);
        x.exp    = (m_state == 0 || m_prev == 2'b11) ? 2'b00 : ref_succ(m_prev);
        sb_q.push_back(x);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            y = sb_q.pop_front();
            check_val("locked_a",    32'(locked_a),    32'(y.locked));
            check_val("err_a",       32'(err_a),       32'(y.err));
            check_val("err_count_a", 32'(err_count_a), 32'(y.cnt8));
            check_val("expected_a",  32'(expected_a),  32'(y.exp));
            check_val("locked_b",    32'(locked_b),    32'(y.locked));
            check_val("err_b",       32'(err_b),       32'(y.err));
            check_val("err_count_b", 32'(err_count_b), 32'(y.cnt2));
            check_val("expected_b",  32'(expected_b),  32'(y.exp));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_locked"},   32'(locked_a | locked_b), 32'd0);
        check_val({tag, "_err"},      32'(err_a | err_b),       32'd0);
        check_val({tag, "_cnt_a"},    32'(err_count_a),         32'd0);
        check_val({tag, "_cnt_b"},    32'(err_count_b),         32'd0);
        check_val({tag, "_exp_a"},    32'(expected_a),          32'd0);
        check_val({tag, "_exp_b"},    32'(expected_b),          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0; en = 1'b0; in_count = 2'd0; clear_err = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("por");
        #3 Rst = 1'b1;

        // Acquire lock: 00,01,10,00
        step(1, 2'd0, 0); step(1, 2'd1, 0); step(1, 2'd2, 0); step(1, 2'd0, 0);
        check_val("lock_after_4", 32'(locked_a), 32'd1);
        check_val("exp_after_4",  32'(expected_a), 32'd1);

        // Single miss: 01,10, then 01 (bad), then 10 (good after resync)
        step(1, 2'd1, 0); step(1, 2'd2, 0); step(1, 2'd1, 0); step(1, 2'd2, 0);

        // Two illegal codes drop lock, then relock
        step(1, 2'd3, 0); step(1, 2'd3, 0);
        check_val("unlock_after_11_11", 32'(locked_a), 32'd0);
        step(1, 2'd0, 0); step(1, 2'd1, 0); step(1, 2'd2, 0); step(1, 2'd0, 0);

        // Clear, then 5 isolated violations; clear coincides with the 5th
        step(0, 2'd0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'd2, (i == 4));
            step(1, 2'd0, 0);
        end

        // en=0 hold with arbitrary input, then a correct sample
        for (int i = 0; i < 4; i++) step(0, 2'($urandom_range(0, 3)), 0);
        step(1, 2'd1, 0);

        // Random traffic including illegal codes and clears
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 31) == 0));

        // Drive the 8-bit counter into saturation
        step(0, 2'd0, 1);
        step(1, 2'd0, 0); step(1, 2'd1, 0); step(1, 2'd2, 0); step(1, 2'd0, 0);
        for (int i = 0; i < 258; i++) begin
            step(1, 2'd2, 0);
            step(1, 2'd0, 0);
        end
        check_val("sat_8bit", 32'(err_count_a), 32'd255);

        // Asynchronous reset mid-cycle while locked with err_count=5
        step(0, 2'd0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'd2, 0);
            step(1, 2'd0, 0);
        end
        check_val("pre_rst_cnt", 32'(err_count_a), 32'd5);
        #2 Rst = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        #2 Rst = 1'b1;
        step(1, 2'd2, 0);
        step(1, 2'd0, 0); step(1, 2'd1, 0); step(1, 2'd2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod3_seq_checker.md
Name: mod3_seq_checker

Overview:
- Receive-side companion to the 2-bit mod-3 T-flip-flop counter, whose legal cycle is 00 -> 01 -> 10 -> 00.
- Samples a 2-bit count stream on every enabled clock and acquires lock after a run of legal transitions.
- Once locked, flags and counts sequence violations.
- Used as a self-checking monitor on counter outputs in lab builds and test benches.

Parameters:
- LOCK_CNT, 3: consecutive legal transitions required to enter LOCKED (range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst, input, 1: asynchronous, active-low reset.
- en, input, 1: sample-valid; in_count is captured only on edges where en=1.
- in_count, input, 2: count value under test.
- clear_err, input, 1: synchronous clear of err_count.
- locked, output, 1: high while the state is LOCKED.
- err, output, 1: one-cycle pulse per counted violation.
- err_count, output, ERR_W: saturating violation count.
- expected, output, 2: next value the checker expects.

Behaviour:
- Reset (Rst=0, asynchronous, any time including mid-run):
  - state=IDLE, prev=00, run=0, miss=0.
  - Outputs: locked=0, err=0, err_count=0, expected=00.
- Successor function: nxt(00)=01, nxt(01)=10, nxt(10)=00.
- in_count=11 is an illegal code. It is never a legal transition, and it is never legal as a predecessor.
- Good transition: prev != 11 and in_count == nxt(prev). Any other transition is bad.
- All outputs are registered. Effects of the sample captured at edge N are visible after edge N.
- On edges with en=0:
  - state, prev, run and miss hold; err=0.
  - clear_err still acts.
- States:
  - IDLE: on an enabled sample, prev<=in_count, run<=0, go to HUNT. No check, no err.
  - HUNT:
    - Good transition: run<=run+1.
    - Bad transition: run<=0.
    - When run+1 == LOCK_CNT on a good transition, go to LOCKED and clear run.
    - err is never asserted in HUNT.
    - prev<=in_count on every enabled sample.
  - LOCKED:
    - Good transition: miss<=0.
    - Bad transition: err<=1 for one cycle and err_count increments, saturating at all-ones.
    - Bad transition with miss=0: miss<=1 and stay LOCKED.
    - Bad transition with miss=1 (second consecutive bad): go to HUNT with run=0, miss=0, locked=0.
    - prev<=in_count always, so the checker resyncs to the received value.
- expected:
  - nxt(prev) in HUNT/LOCKED when prev != 11.
  - 00 in IDLE or when prev=11.
- clear_err:
  - Sets err_count<=0.
  - If it coincides with an increment, the clear wins (result 0); err still pulses.
- locked reflects the state register directly. It rises on the edge that completes the LOCK_CNT-th good transition.

Test Plan:
- Reset then en=1, samples 00,01,10,00 (LOCK_CNT=3): locked=0 after samples 1–3, locked=1 after sample 4; err never high; expected=01 after sample 4.
- Locked; after 10, sample 01: err=1 for one cycle, err_count=1, locked stays 1. Next sample 10: good, err=0, miss cleared, locked=1.
- Locked; samples 11 then 11: err pulses twice, err_count=2. After the second, locked=0 and the state is HUNT. Then 00,01,10,00 relocks after the 4th sample.
- ERR_W=2, locked; induce 5 isolated violations separated by good samples: err_count reads 1,2,3,3,3. Assert clear_err on the cycle of the 5th violation: err_count=0, err=1.
- Locked; toggle en=0 for 4 cycles while in_count changes arbitrarily: no state change, err=0, expected held. Resume with a correct sample: no error.
- Mid-run Rst=0 pulse asynchronous to Clk while locked with err_count=5: all outputs clear immediately. After release, the first sample yields HUNT, with no err.
